// File: rtl/ref_mem_ctrl_if.sv
// Bus bundle between the reference-memory controller and its master (write stream, read commands, bank controls).
// With REF_MEM_CTRL_STALL_CNT_EN defined, the bundle also carries the issue-gate stall counter.
interface ref_mem_ctrl_if #(parameter int AW = 7);
  logic              fill_clr;
  logic              wr_valid;
  logic              wr_ready;
  logic [255:0]      wr_data;
  logic              rd_cmd_valid;
  logic              rd_cmd_ready;
  logic [AW-1:0]     rd_cmd_addr;
  logic [AW-1:0]     rd_cmd_len;
  logic              rd_cmd_mode;
  logic              rd_busy;
  logic              rd_done;
  logic              rd_err;
  logic [255:0]      ref_input;
  logic [31:0]       Bank_sel;
  logic [32*AW-1:0]  write_address_all;
  logic [AW-1:0]     rd_address;
  logic              rd8R_en;
  logic [3:0]        rdR_sel;
`ifdef REF_MEM_CTRL_STALL_CNT_EN
  logic [15:0]       stall_cnt;

  modport slave (
    input  fill_clr, wr_valid, wr_data, rd_cmd_valid, rd_cmd_addr, rd_cmd_len, rd_cmd_mode,
    output wr_ready, rd_cmd_ready, rd_busy, rd_done, rd_err, ref_input, Bank_sel,
           write_address_all, rd_address, rd8R_en, rdR_sel, stall_cnt
  );
  modport master (
    output fill_clr, wr_valid, wr_data, rd_cmd_valid, rd_cmd_addr, rd_cmd_len, rd_cmd_mode,
    input  wr_ready, rd_cmd_ready, rd_busy, rd_done, rd_err, ref_input, Bank_sel,
           write_address_all, rd_address, rd8R_en, rdR_sel, stall_cnt
  );
`else
  modport slave (
    input  fill_clr, wr_valid, wr_data, rd_cmd_valid, rd_cmd_addr, rd_cmd_len, rd_cmd_mode,
    output wr_ready, rd_cmd_ready, rd_busy, rd_done, rd_err, ref_input, Bank_sel,
           write_address_all, rd_address, rd8R_en, rdR_sel
  );
  modport master (
    output fill_clr, wr_valid, wr_data, rd_cmd_valid, rd_cmd_addr, rd_cmd_len, rd_cmd_mode,
    input  wr_ready, rd_cmd_ready, rd_busy, rd_done, rd_err, ref_input, Bank_sel,
           write_address_all, rd_address, rd8R_en, rdR_sel
  );
`endif
endinterface

// File: rtl/ref_mem_ctrl.sv
// Reference search-window memory controller: row write scheduler, fill scoreboard and range read sequencer.
// Optional REF_MEM_CTRL_STALL_CNT_EN adds a saturating counter of issue-gate stall cycles.
module ref_mem_ctrl #(
  parameter int DEPTH = 96,
  parameter int AW    = 7
) (
  input  logic         clk,
  input  logic         rst,
  ref_mem_ctrl_if.slave bus
);
  localparam int            RCW  = $clog2(DEPTH*8+1);
  localparam logic [RCW-1:0] ROWS = RCW'(DEPTH*8);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN8  = 2'd1;
  localparam logic [1:0] S_RUN1  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [RCW-1:0] r_row_cnt;
  logic [AW-1:0]  r_done_addr;
  logic [255:0]   r_ref_input;
  logic [31:0]    r_bank_sel;
  logic [AW-1:0]  r_wr_addr;

  logic [1:0]     r_state;
  logic [AW-1:0]  r_cur;
  logic [AW-1:0]  r_rem;
  logic [AW-1:0]  r_rd_addr;
  logic [2:0]     r_sub;
  logic [1:0]     r_drain_cnt;
  logic           r_drain_long;
  logic           r_clip;
  logic [3:0]     r_rdR_sel;

  logic           w_wr_ready, w_wr_acc;
  logic           w_cmd_ready, w_cmd_acc;
  logic           w_gate_ok, w_issue, w_stall, w_done;
  logic [AW-1:0]  w_avail, w_len_c;
  logic           w_clip;

  assign w_wr_ready  = ~rst & (r_row_cnt < ROWS) & ~bus.fill_clr;
  assign w_wr_acc    = bus.wr_valid & w_wr_ready;
  assign w_cmd_ready = ~rst & (r_state == S_IDLE) & ~bus.fill_clr;
  assign w_cmd_acc   = bus.rd_cmd_valid & w_cmd_ready;
  assign w_gate_ok   = r_cur < r_done_addr;

  assign w_avail = (bus.rd_cmd_addr < AW'(DEPTH)) ? AW'(DEPTH) - bus.rd_cmd_addr : '0;
  assign w_clip  = bus.rd_cmd_len > w_avail;
  assign w_len_c = w_clip ? w_avail : bus.rd_cmd_len;

  // Row-by-row replay only gates on the first of the eight cycles per address
  always_comb begin
    w_issue = 1'b0;
    w_stall = 1'b0;
    case (r_state)
      S_RUN8: begin
        w_issue = w_gate_ok;
        w_stall = ~w_gate_ok;
      end
      S_RUN1: begin
        if (r_sub == 3'd0) begin
          w_issue = w_gate_ok;
          w_stall = ~w_gate_ok;
        end else begin
          w_issue = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Single-row replay goes through the extra row-select stage, so its drain is one cycle longer
  assign w_done = (r_state == S_DRAIN) && (r_drain_cnt == (r_drain_long ? 2'd2 : 2'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_cnt   <= '0;
      r_done_addr <= '0;
      r_ref_input <= '0;
      r_bank_sel  <= '0;
      r_wr_addr   <= '0;
    end else if (bus.fill_clr) begin
      r_row_cnt   <= '0;
      r_done_addr <= '0;
      r_bank_sel  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_ref_input <= bus.wr_data;
        r_bank_sel  <= 32'hF << {r_row_cnt[2:0], 2'b00};
        r_wr_addr   <= AW'(r_row_cnt >> 3);
        r_row_cnt   <= r_row_cnt + 1'b1;
      end else begin
        r_bank_sel  <= '0;
      end
      // Top bank group written this cycle completes an address at the end of it
      if (|r_bank_sel[31:28])
        r_done_addr <= r_done_addr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cur        <= '0;
      r_rem        <= '0;
      r_rd_addr    <= '0;
      r_sub        <= '0;
      r_drain_cnt  <= '0;
      r_drain_long <= 1'b0;
      r_clip       <= 1'b0;
      r_rdR_sel    <= '0;
    end else if (bus.fill_clr) begin
      r_state     <= S_IDLE;
      r_sub       <= '0;
      r_drain_cnt <= '0;
      r_rdR_sel   <= '0;
    end else begin
      r_rdR_sel <= (r_state == S_RUN1 && w_issue) ? {1'b0, r_sub} + 4'd1 : 4'd0;
      if (w_issue)
        r_rd_addr <= r_cur;
      case (r_state)
        S_IDLE: if (w_cmd_acc) begin
          r_cur        <= bus.rd_cmd_addr;
          r_rem        <= w_len_c;
          r_clip       <= w_clip;
          r_drain_long <= bus.rd_cmd_mode & (w_len_c != '0);
          r_sub        <= '0;
          r_drain_cnt  <= '0;
          if (w_len_c == '0)        r_state <= S_DRAIN;
          else if (bus.rd_cmd_mode) r_state <= S_RUN1;
          else                      r_state <= S_RUN8;
        end
        S_RUN8: if (w_issue) begin
          r_cur <= r_cur + 1'b1;
          r_rem <= r_rem - 1'b1;
          if (r_rem == AW'(1)) r_state <= S_DRAIN;
        end
        S_RUN1: if (w_issue) begin
          r_sub <= r_sub + 1'b1;
          if (r_sub == 3'd7) begin
            r_cur <= r_cur + 1'b1;
            r_rem <= r_rem - 1'b1;
            if (r_rem == AW'(1)) r_state <= S_DRAIN;
          end
        end
        default: begin
          r_drain_cnt <= r_drain_cnt + 1'b1;
          if (w_done) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= '0;
          end
        end
      endcase
    end
  end

`ifdef REF_MEM_CTRL_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_stall_cnt <= '0;
    else if (bus.fill_clr || w_cmd_acc)       r_stall_cnt <= '0;
    else if (w_stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 1'b1;
  end
  assign bus.stall_cnt = r_stall_cnt;
`else
  logic w_stall_unused;
  assign w_stall_unused = w_stall;
`endif

  assign bus.wr_ready          = w_wr_ready;
  assign bus.rd_cmd_ready      = w_cmd_ready;
  assign bus.rd_busy           = (r_state != S_IDLE);
  assign bus.rd_done           = w_done;
  assign bus.rd_err            = w_done & r_clip;
  assign bus.ref_input         = r_ref_input;
  assign bus.Bank_sel          = r_bank_sel;
  assign bus.write_address_all = {32{r_wr_addr}};
  assign bus.rd_address        = w_issue ? r_cur : r_rd_addr;
  assign bus.rd8R_en           = w_issue;
  assign bus.rdR_sel           = r_rdR_sel;
endmodule

// File: tb/tb_ref_mem_ctrl.sv
// Directed bench for ref_mem_ctrl: window fill, 8-row and row-by-row replay, fill gating, clipping, abort, reset.
module tb_ref_mem_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ref_mem_ctrl_if #(.AW(7)) bus();
  ref_mem_ctrl #(.DEPTH(96), .AW(7)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [223:0] rep(input int n);
    logic [223:0] v;
    for (int j = 0; j < 32; j++) v[j*7 +: 7] = 7'(n);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One read-side cycle: check outputs, then advance
  task automatic cyc(input string tag, input logic en, input int addr, input int sel,
                     input logic done, input logic err, input logic busy);
    #1;
    chk({tag, ".en"},   bus.rd8R_en,    en);
    chk({tag, ".addr"}, bus.rd_address, 256'(addr));
    chk({tag, ".sel"},  bus.rdR_sel,    256'(sel));
    chk({tag, ".done"}, bus.rd_done,    done);
    chk({tag, ".err"},  bus.rd_err,     err);
    chk({tag, ".busy"}, bus.rd_busy,    busy);
    tick();
  endtask

  task automatic cmd(input int addr, input int len, input logic mode);
    bus.rd_cmd_valid = 1'b1;
    bus.rd_cmd_addr  = 7'(addr);
    bus.rd_cmd_len   = 7'(len);
    bus.rd_cmd_mode  = mode;
    #1;
    chk("cmd_ready", bus.rd_cmd_ready, 1'b1);
    tick();
    bus.rd_cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.fill_clr = 1'b0; bus.wr_valid = 1'b0; bus.wr_data = '0;
    bus.rd_cmd_valid = 1'b0; bus.rd_cmd_addr = '0; bus.rd_cmd_len = '0; bus.rd_cmd_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.bank_sel", bus.Bank_sel, 32'h0);
    chk("rst.ref_input", bus.ref_input, 256'h0);
    chk("rst.wr_addr", bus.write_address_all, 224'h0);
    chk("rst.rd_en", bus.rd8R_en, 1'b0);
    chk("rst.rdR_sel", bus.rdR_sel, 4'h0);
    chk("rst.busy", bus.rd_busy, 1'b0);
    chk("rst.done", bus.rd_done, 1'b0);
    chk("rst.wr_ready", bus.wr_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst.wr_ready", bus.wr_ready, 1'b1);
    chk("post_rst.cmd_ready", bus.rd_cmd_ready, 1'b1);
    tick();

    // Full window fill, one beat per cycle, data = row index
    for (int r = 0; r < 768; r++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 256'(r);
      #1;
      chk("fill.wr_ready", bus.wr_ready, 1'b1);
      if (r > 0) begin
        chk("fill.bank_sel", bus.Bank_sel, 32'hF << (4 * ((r - 1) % 8)));
        chk("fill.wr_addr", bus.write_address_all, rep((r - 1) / 8));
        chk("fill.ref_input", bus.ref_input, 256'(r - 1));
      end
      tick();
    end
    bus.wr_valid = 1'b0;
    #1;
    chk("full.wr_ready", bus.wr_ready, 1'b0);
    chk("full.bank_sel", bus.Bank_sel, 32'hF000_0000);
    chk("full.wr_addr", bus.write_address_all, rep(95));
    chk("full.ref_input", bus.ref_input, 256'(767));
    tick();
    #1;
    chk("idle.bank_sel", bus.Bank_sel, 32'h0);
    chk("idle.ref_input_hold", bus.ref_input, 256'(767));
    tick();

    // 8-row replay of 5..7
    cmd(5, 3, 1'b0);
    cyc("r8a", 1'b1, 5, 0, 1'b0, 1'b0, 1'b1);
    cyc("r8b", 1'b1, 6, 0, 1'b0, 1'b0, 1'b1);
    cyc("r8c", 1'b1, 7, 0, 1'b0, 1'b0, 1'b1);
    cyc("r8d", 1'b0, 7, 0, 1'b0, 1'b0, 1'b1);
    cyc("r8e", 1'b0, 7, 0, 1'b1, 1'b0, 1'b1);
    cyc("r8f", 1'b0, 7, 0, 1'b0, 1'b0, 1'b0);

    // Row-by-row replay of address 2
    cmd(2, 1, 1'b1);
    for (int k = 1; k <= 8; k++) cyc("r1", 1'b1, 2, k - 1, 1'b0, 1'b0, 1'b1);
    cyc("r1d1", 1'b0, 2, 8, 1'b0, 1'b0, 1'b1);
    cyc("r1d2", 1'b0, 2, 0, 1'b0, 1'b0, 1'b1);
    cyc("r1d3", 1'b0, 2, 0, 1'b1, 1'b0, 1'b1);
    cyc("r1d4", 1'b0, 2, 0, 1'b0, 1'b0, 1'b0);

    // Range clipped at the top of the window
    cmd(94, 5, 1'b0);
    cyc("clipa", 1'b1, 94, 0, 1'b0, 1'b0, 1'b1);
    cyc("clipb", 1'b1, 95, 0, 1'b0, 1'b0, 1'b1);
    cyc("clipc", 1'b0, 95, 0, 1'b0, 1'b0, 1'b1);
    cyc("clipd", 1'b0, 95, 0, 1'b1, 1'b1, 1'b1);
    cyc("clipe", 1'b0, 95, 0, 1'b0, 1'b0, 1'b0);

    // Zero-length command
    cmd(10, 0, 1'b0);
    cyc("len0a", 1'b0, 95, 0, 1'b0, 1'b0, 1'b1);
    cyc("len0b", 1'b0, 95, 0, 1'b1, 1'b0, 1'b1);
    cyc("len0c", 1'b0, 95, 0, 1'b0, 1'b0, 1'b0);

    // Restart fill, load 16 rows, then read ahead of the fill
    bus.fill_clr = 1'b1;
    #1;
    chk("clr.wr_ready", bus.wr_ready, 1'b0);
    chk("clr.cmd_ready", bus.rd_cmd_ready, 1'b0);
    tick();
    bus.fill_clr = 1'b0;
    for (int r = 0; r < 16; r++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 256'(1000 + r);
      tick();
    end
    bus.wr_valid = 1'b0;
    cmd(0, 4, 1'b0);
    cyc("parta", 1'b1, 0, 0, 1'b0, 1'b0, 1'b1);
    cyc("partb", 1'b1, 1, 0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      if (c < 16) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = 256'(16 + c);
      end else begin
        bus.wr_valid = 1'b0;
      end
      cyc("gate", (c == 9 || c == 17), (c < 9) ? 1 : ((c < 17) ? 2 : 3), 0, (c == 19), 1'b0, 1'b1);
    end
    cyc("gate_end", 1'b0, 3, 0, 1'b0, 1'b0, 1'b0);

    // Abort a row-by-row read mid-address; the beat offered alongside must be dropped
    cmd(1, 2, 1'b1);
    cyc("aba", 1'b1, 1, 0, 1'b0, 1'b0, 1'b1);
    cyc("abb", 1'b1, 1, 1, 1'b0, 1'b0, 1'b1);
    cyc("abc", 1'b1, 1, 2, 1'b0, 1'b0, 1'b1);
    bus.fill_clr = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 256'hDEAD;
    #1;
    chk("ab.en_before", bus.rd8R_en, 1'b1);
    chk("ab.sel_before", bus.rdR_sel, 4'd3);
    chk("ab.wr_ready", bus.wr_ready, 1'b0);
    tick();
    bus.fill_clr = 1'b0;
    bus.wr_valid = 1'b0;
    #1;
    chk("ab.wr_ready_after", bus.wr_ready, 1'b1);
    chk("ab.bank_sel_after", bus.Bank_sel, 32'h0);
    chk("ab.cmd_ready_after", bus.rd_cmd_ready, 1'b1);
    cyc("abd", 1'b0, 1, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) cyc("ab_nodone", 1'b0, 1, 0, 1'b0, 1'b0, 1'b0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 256'hABC;
    tick();
    bus.wr_valid = 1'b0;
    #1;
    chk("ab.row0_bank_sel", bus.Bank_sel, 32'h0000_000F);
    chk("ab.row0_wr_addr", bus.write_address_all, rep(0));
    chk("ab.row0_data", bus.ref_input, 256'hABC);

    // Asynchronous reset in the middle of a write
    bus.wr_valid = 1'b1;
    bus.wr_data  = 256'h1;
    tick();
    #1;
    chk("arst.bank_sel_before", bus.Bank_sel, 32'h0000_00F0);
    rst = 1'b1;
    #1;
    chk("arst.bank_sel", bus.Bank_sel, 32'h0);
    chk("arst.ref_input", bus.ref_input, 256'h0);
    chk("arst.wr_addr", bus.write_address_all, 224'h0);
    chk("arst.wr_ready", bus.wr_ready, 1'b0);
    tick();
    rst = 1'b0;
    bus.wr_valid = 1'b0;
    #1;
    chk("arst.wr_ready_after", bus.wr_ready, 1'b1);
    chk("arst.busy_after", bus.rd_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
